// File: rtl/scan_demux_pkg.sv
// Shared definitions for the scanned seven-segment digit demultiplexer.
// Contents: scan FSM state encoding, default TIMEOUT / LOCK_FRAMES values,
//           and a helper that sizes counters for a given maximum value.
package scan_demux_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    LOCKED  = 2'd2
  } scan_state_t;

  localparam int TIMEOUT_DEF     = 1024;
  localparam int LOCK_FRAMES_DEF = 2;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/scan_watchdog.sv
// Purpose: counts cycles since the last accepted strobe while a frame is open.
// Latency: EXPIRED is high the cycle after TIMEOUT idle cycles have elapsed.
// Backpressure: none. Ports: CLK, RST (sync, active-high), CLR (restart),
//               EN (count enable, low holds count at 0), EXPIRED (timeout).
module scan_watchdog
  import scan_demux_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic EXPIRED
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt;

  // cnt = number of edges since the last clear. A strobe exactly TIMEOUT
  // cycles after the previous one still sees cnt == TIMEOUT-1 and is
  // accepted; one cycle later EXPIRED fires and outranks any strobe.
  always_ff @(posedge CLK) begin
    if (RST || CLR || !EN) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign EXPIRED = EN && (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/scan_demux.sv
// Purpose: rebuilds 4-digit frames from a scanned (slot strobe + index) bus.
// Latency: DIG0..3/FRAME_STB update one cycle after the slot-3 strobe.
// Backpressure: none; every SEL_STB is processed, back-to-back is legal.
// Ports: CLK, RST (sync, active-high); SEL_STB/SEL_IDX/DIG_IN scan input;
//        DIG0..DIG3 frame digits, FRAME_STB update pulse, FRAME_VALID lock,
//        SEQ_ERR pulse on order violation or timeout.
module scan_demux
  import scan_demux_pkg::*;
#(
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEL_STB,
  input  logic [1:0] SEL_IDX,
  input  logic [3:0] DIG_IN,
  output logic [3:0] DIG0,
  output logic [3:0] DIG1,
  output logic [3:0] DIG2,
  output logic [3:0] DIG3,
  output logic       FRAME_STB,
  output logic       FRAME_VALID,
  output logic       SEQ_ERR
);

  localparam int GW = cnt_width(LOCK_FRAMES);

  scan_state_t   state;
  logic [1:0]    exp_idx;
  logic [3:0]    sh0, sh1, sh2;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] good_inc;
  logic          in_frame;
  logic          accept;
  logic          tmo;

  assign in_frame = (state != HUNT);

  // Any strobe that lands in a slot: the expected one, or a slot 0 that
  // restarts a frame (from HUNT or after an order error). A timeout on the
  // same edge overrides it.
  assign accept = SEL_STB && !tmo &&
                  ((in_frame && (SEL_IDX == exp_idx)) || (SEL_IDX == 2'd0));

  always_comb begin
    good_inc = good_cnt;
    if (good_cnt != GW'(LOCK_FRAMES)) begin
      good_inc = good_cnt + 1'b1;
    end
  end

  scan_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .CLK    (CLK),
    .RST    (RST),
    .CLR    (accept),
    .EN     (in_frame),
    .EXPIRED(tmo)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= HUNT;
      exp_idx     <= 2'd0;
      sh0         <= 4'd0;
      sh1         <= 4'd0;
      sh2         <= 4'd0;
      good_cnt    <= '0;
      DIG0        <= 4'd0;
      DIG1        <= 4'd0;
      DIG2        <= 4'd0;
      DIG3        <= 4'd0;
      FRAME_STB   <= 1'b0;
      FRAME_VALID <= 1'b0;
      SEQ_ERR     <= 1'b0;
    end else begin
      FRAME_STB <= 1'b0;
      SEQ_ERR   <= 1'b0;
      if (tmo) begin
        // Timeout wins over a coincident strobe, including a slot-3 one.
        SEQ_ERR     <= 1'b1;
        good_cnt    <= '0;
        FRAME_VALID <= 1'b0;
        exp_idx     <= 2'd0;
        state       <= HUNT;
      end else if (state == HUNT) begin
        if (SEL_STB && (SEL_IDX == 2'd0)) begin
          sh0     <= DIG_IN;
          exp_idx <= 2'd1;
          state   <= COLLECT;
        end
      end else if (SEL_STB) begin
        if (SEL_IDX == exp_idx) begin
          exp_idx <= exp_idx + 1'b1;
          case (exp_idx)
            2'd0: sh0 <= DIG_IN;
            2'd1: sh1 <= DIG_IN;
            2'd2: sh2 <= DIG_IN;
            default: begin
              DIG0      <= sh0;
              DIG1      <= sh1;
              DIG2      <= sh2;
              DIG3      <= DIG_IN;
              FRAME_STB <= 1'b1;
              good_cnt  <= good_inc;
              if (good_inc == GW'(LOCK_FRAMES)) begin
                state       <= LOCKED;
                FRAME_VALID <= 1'b1;
              end
            end
          endcase
        end else begin
          SEQ_ERR     <= 1'b1;
          good_cnt    <= '0;
          FRAME_VALID <= 1'b0;
          if (SEL_IDX == 2'd0) begin
            // The offending strobe is itself a valid frame start.
            sh0     <= DIG_IN;
            exp_idx <= 2'd1;
            state   <= COLLECT;
          end else begin
            exp_idx <= 2'd0;
            state   <= HUNT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_demux.sv
// Scoreboard bench for scan_demux: stimulus pushes expected frame/error
// events (with the cycle they must appear in); a negedge monitor pops and
// compares them against FRAME_STB / SEQ_ERR.
module tb_scan_demux;

  localparam int TB_TIMEOUT = 1024;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SEL_STB = 1'b0;
  logic [1:0] SEL_IDX = 2'd0;
  logic [3:0] DIG_IN = 4'd0;
  logic [3:0] DIG0, DIG1, DIG2, DIG3;
  logic       FRAME_STB, FRAME_VALID, SEQ_ERR;

  typedef struct {
    logic [15:0] dig;
    logic        vld;
    int          cyc;
  } frame_exp_t;

  frame_exp_t frame_q[$];
  int         err_q[$];
  int         cyc = 0;
  int         drv_cyc = 0;
  int         tests = 0;
  int         fails = 0;

  scan_demux #(
    .TIMEOUT    (TB_TIMEOUT),
    .LOCK_FRAMES(2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SEL_STB    (SEL_STB),
    .SEL_IDX    (SEL_IDX),
    .DIG_IN     (DIG_IN),
    .DIG0       (DIG0),
    .DIG1       (DIG1),
    .DIG2       (DIG2),
    .DIG3       (DIG3),
    .FRAME_STB  (FRAME_STB),
    .FRAME_VALID(FRAME_VALID),
    .SEQ_ERR    (SEQ_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (frame_q.size() > 0 && frame_q[0].cyc < cyc) begin
      check("frame_stb_missing_at_cycle", 32'(cyc), 32'(frame_q[0].cyc));
      void'(frame_q.pop_front());
    end
    if (err_q.size() > 0 && err_q[0] < cyc) begin
      check("seq_err_missing_at_cycle", 32'(cyc), 32'(err_q[0]));
      void'(err_q.pop_front());
    end
    if (FRAME_STB === 1'b1) begin
      if (frame_q.size() == 0) begin
        check("unexpected_frame_stb", 32'(FRAME_STB), 32'd0);
      end else begin
        frame_exp_t e;
        e = frame_q.pop_front();
        check("frame_digits", {16'd0, DIG3, DIG2, DIG1, DIG0}, {16'd0, e.dig});
        check("frame_valid_at_stb", 32'(FRAME_VALID), 32'(e.vld));
        check("frame_stb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (SEQ_ERR === 1'b1) begin
      if (err_q.size() == 0) begin
        check("unexpected_seq_err", 32'(SEQ_ERR), 32'd0);
      end else begin
        int at;
        at = err_q.pop_front();
        check("seq_err_cycle", 32'(cyc), 32'(at));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic strobe(input logic [1:0] idx, input logic [3:0] dig);
    @(posedge CLK); #1;
    SEL_STB = 1'b1;
    SEL_IDX = idx;
    DIG_IN  = dig;
    drv_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      SEL_STB = 1'b0;
      SEL_IDX = 2'($urandom);
      DIG_IN  = 4'($urandom);
    end
  endtask

  task automatic expect_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic v, input int at);
    frame_exp_t e;
    e.dig = {d, c, b, a};
    e.vld = v;
    e.cyc = at;
    frame_q.push_back(e);
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic v);
    strobe(2'd0, a);
    strobe(2'd1, b);
    strobe(2'd2, c);
    strobe(2'd3, d);
    expect_frame(a, b, c, d, v, drv_cyc + 1);
  endtask

  task automatic check_outputs(input string name, input logic [15:0] dig, input logic vld);
    @(negedge CLK);
    check({name, "_digits"}, {16'd0, DIG3, DIG2, DIG1, DIG0}, {16'd0, dig});
    check({name, "_valid"}, 32'(FRAME_VALID), 32'(vld));
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired, required finish");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d;
    RST = 1'b1;
    idle(3);
    @(negedge CLK);
    check("reset_outputs", {25'd0, FRAME_STB, FRAME_VALID, SEQ_ERR, DIG3}, 32'd0);
    check("reset_digits", {16'd0, DIG3, DIG2, DIG1, DIG0}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle(2);

    // Four clean frames: lock on the second.
    frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    idle(3);
    frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);

    // Locked, then idx 0,1,3: order error on the idx-3 strobe.
    strobe(2'd0, 4'd9);
    strobe(2'd1, 4'd9);
    strobe(2'd3, 4'd9);
    err_q.push_back(drv_cyc + 1);
    idle(2);
    check_outputs("after_order_err", 16'h4321, 1'b0);

    // HUNT ignores idx 2,3; then frames of 5,6,7,8.
    strobe(2'd2, 4'd1);
    strobe(2'd3, 4'd1);
    frame(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
    frame(4'd5, 4'd6, 4'd7, 4'd8, 1'b1);

    // Out-of-order slot 0 is an error but also starts a new frame.
    strobe(2'd0, 4'd9);
    strobe(2'd1, 4'd9);
    strobe(2'd0, 4'hA);
    err_q.push_back(drv_cyc + 1);
    strobe(2'd1, 4'hB);
    strobe(2'd2, 4'hC);
    strobe(2'd3, 4'hD);
    expect_frame(4'hA, 4'hB, 4'hC, 4'hD, 1'b0, drv_cyc + 1);
    frame(4'hE, 4'hF, 4'h0, 4'h1, 1'b1);

    // Timeout while locked: idx 0,1 then silence.
    strobe(2'd0, 4'd2);
    strobe(2'd1, 4'd2);
    err_q.push_back(drv_cyc + TB_TIMEOUT + 2);
    idle(TB_TIMEOUT + 6);
    check_outputs("after_timeout", 16'h10FE, 1'b0);
    // Back in HUNT: non-zero indices are ignored without error.
    strobe(2'd1, 4'd3);
    strobe(2'd3, 4'd3);
    idle(2);

    // A gap of exactly TIMEOUT cycles between strobes is still legal.
    strobe(2'd0, 4'd1);
    strobe(2'd1, 4'd2);
    idle(TB_TIMEOUT - 1);
    strobe(2'd2, 4'd3);
    strobe(2'd3, 4'd4);
    expect_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, drv_cyc + 1);
    frame(4'd5, 4'd6, 4'd7, 4'd8, 1'b1);

    // Slot 3 arriving on the timeout edge: error wins, no frame.
    strobe(2'd0, 4'd9);
    strobe(2'd1, 4'd9);
    strobe(2'd2, 4'd9);
    d = drv_cyc;
    idle(TB_TIMEOUT);
    strobe(2'd3, 4'd9);
    err_q.push_back(d + TB_TIMEOUT + 2);
    idle(2);
    check_outputs("timeout_beats_slot3", 16'h8765, 1'b0);

    // Relock, then reset during slot 2 (overrides the concurrent strobe).
    frame(4'd3, 4'd1, 4'd4, 4'd1, 1'b0);
    frame(4'd5, 4'd9, 4'd2, 4'd6, 1'b1);
    strobe(2'd0, 4'd7);
    strobe(2'd1, 4'd7);
    @(posedge CLK); #1;
    RST = 1'b1;
    SEL_STB = 1'b1;
    SEL_IDX = 2'd2;
    DIG_IN = 4'd7;
    @(posedge CLK); #1;
    RST = 1'b0;
    SEL_STB = 1'b0;
    @(negedge CLK);
    check("midframe_reset_outputs", {28'd0, FRAME_STB, FRAME_VALID, SEQ_ERR, 1'b0}, 32'd0);
    check("midframe_reset_digits", {16'd0, DIG3, DIG2, DIG1, DIG0}, 32'd0);
    frame(4'd2, 4'd7, 4'd1, 4'd8, 1'b0);
    frame(4'd2, 4'd8, 4'd1, 4'd8, 1'b1);

    // Back-to-back strobes every cycle: FRAME_STB every 4 cycles.
    frame(4'h1, 4'h3, 4'h5, 4'h7, 1'b1);
    frame(4'h2, 4'h4, 4'h6, 4'h8, 1'b1);
    frame(4'hF, 4'hE, 4'hD, 4'hC, 1'b1);

    idle(4);
    @(negedge CLK);
    check("frame_queue_drained", 32'(frame_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);
    check("final_state", {16'd0, DIG3, DIG2, DIG1, DIG0}, 32'h0000CDEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_demux.md
SCAN_DEMUX -- requirements
Module: scan_demux

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning the maximum clock cycles allowed between consecutive SEL_STB pulses inside a frame.
REQ-002 SHALL have parameter LOCK_FRAMES, default 2, meaning the number of consecutive good frames required before FRAME_VALID asserts.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port SEL_STB, input, 1 bit: one-cycle strobe marking a new digit slot on the scanned bus.
REQ-006 SHALL have port SEL_IDX, input, 2 bits: digit slot index (0..3), qualified by SEL_STB.
REQ-007 SHALL have port DIG_IN, input, 4 bits: digit value for slot SEL_IDX, qualified by SEL_STB.
REQ-008 SHALL have ports DIG0, DIG1, DIG2, DIG3, output, 4 bits each: the last completed frame's digit values, registered.
REQ-009 SHALL have port FRAME_STB, output, 1 bit: one-cycle pulse when DIG0..DIG3 update.
REQ-010 SHALL have port FRAME_VALID, output, 1 bit: the scan is locked.
REQ-011 SHALL have port SEQ_ERR, output, 1 bit: one-cycle pulse on an order violation or timeout.

Function
REQ-012 SHALL implement states HUNT, COLLECT and LOCKED; the scan position is tracked by a 2-bit expected-index counter EXP.
REQ-013 In HUNT, SHALL ignore SEL_STB with SEL_IDX != 0; SEL_STB with SEL_IDX == 0 SHALL capture DIG_IN into shadow slot 0, set EXP=1 and go to COLLECT.
REQ-014 In COLLECT or LOCKED, SEL_STB with SEL_IDX == EXP SHALL capture DIG_IN into shadow[EXP] and increment EXP, wrapping from 3 to 0.
REQ-015 Capture of slot 3 SHALL copy shadow0..2 plus the current DIG_IN into DIG0..DIG3 on the same edge; FRAME_STB SHALL be high in the following cycle (1-cycle latency from the slot-3 strobe).
REQ-016 SHALL count good frames with a saturating counter; when the count reaches LOCK_FRAMES the state SHALL become LOCKED and FRAME_VALID SHALL be 1 from that frame's FRAME_STB cycle onward.
REQ-017 In COLLECT or LOCKED, SEL_STB with SEL_IDX != EXP SHALL pulse SEQ_ERR, discard the partial frame, clear the good-frame counter and FRAME_VALID, and go to HUNT; if the offending SEL_IDX == 0, that strobe SHALL itself be accepted as a new slot 0 (state COLLECT, EXP=1).
REQ-018 A timeout counter SHALL reset on every accepted SEL_STB and count in COLLECT and LOCKED; on reaching TIMEOUT cycles without an accepted strobe, it SHALL take the same action as REQ-017 (no re-acceptance).
REQ-019 DIG0..DIG3 SHALL hold their last values through errors and HUNT; they SHALL change only on frame completion.
REQ-020 SEL_STB on consecutive cycles SHALL be legal; each strobe is processed independently.
REQ-021 When an error and a slot-3 completion coincide, the error SHALL win: no FRAME_STB and no output update.
REQ-022 SEL_IDX and DIG_IN SHALL be don't-care when SEL_STB is 0.

Reset
REQ-023 When RST is high at a rising CLK edge, SHALL set state HUNT, EXP=0, counters 0, shadow and DIG0..DIG3 to 4'd0, and FRAME_STB, FRAME_VALID and SEQ_ERR to 0; this overrides any concurrent SEL_STB.
REQ-024 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL still require LOCK_FRAMES good frames before FRAME_VALID.

Structure
REQ-025 The state encoding (HUNT/COLLECT/LOCKED) and the default TIMEOUT and LOCK_FRAMES values SHALL live in the shared seven-segment package.
REQ-026 The timeout counter SHALL be a sub-module named scan_watchdog, with inputs CLK, RST, CLR and EN, and output EXPIRED.

Verification
REQ-027 Reset, then four frames of slots 0..3 with DIG_IN 1,2,3,4 -> FRAME_STB once per frame, DIG0..3 = 1,2,3,4, FRAME_VALID high from frame 2.
REQ-028 Stream starting at idx 2,3 then 0..3 with values 5,6,7,8 -> no SEQ_ERR during HUNT; first frame output is 5,6,7,8.
REQ-029 While locked, send idx 0,1,3 -> SEQ_ERR pulse on the idx-3 strobe, FRAME_VALID drops, DIG0..3 unchanged.
REQ-030 While locked, send idx 0,1, then idle 1024 cycles -> SEQ_ERR pulse exactly at TIMEOUT, state HUNT.
REQ-031 Assert RST during slot 2 of a frame -> all outputs 0 next cycle; the following two full frames give FRAME_VALID only after the second.
REQ-032 Back-to-back SEL_STB every cycle, idx 0,1,2,3 repeating -> FRAME_STB every 4 cycles with correct digits.
